call_return_ctrl: RTL and testbench
===================================

Name: call_return_ctrl

Overview:
- Client-side controller for the hardware return-address stack used by the pipelined MIPS core.
- Converts decode-stage CALL (jal/jalr) and RET (jr $ra) events into stack PUSH/POP requests.
- Sequences the one-cycle pop-data latency, stalls decode while a return address is in flight, and raises sticky overflow/underflow exceptions.
- Sits between the ID stage and the stack instance; it drives the stack's PUSH, POP and Data_in, and consumes its Data_out, FULL and EMPTY.

Parameters:
ADDR_WIDTH, 32, width of return addresses (matches stack word width)
DEPTH_WIDTH, 6, stack pointer width; local depth counter is DEPTH_WIDTH+1 bits

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
CALL  input  1  decode has a valid call this cycle
RET  input  1  decode has a valid return this cycle
CALL_PC  input  ADDR_WIDTH  return address to save (PC+8) for CALL
FLUSH  input  1  pipeline flush; cancels a pending return delivery
CLR_EXC  input  1  clears sticky exceptions and leaves ERR
STK_FULL  input  1  stack full flag
STK_EMPTY  input  1  stack empty flag
STK_DOUT  input  ADDR_WIDTH  stack pop data, valid the cycle after POP
STK_PUSH  output  1  push request (combinational)
STK_POP  output  1  pop request (combinational)
STK_DIN  output  ADDR_WIDTH  push data (= CALL_PC, combinational)
STALL  output  1  hold decode stage
RET_VALID  output  1  one-cycle pulse: RET_ADDR valid
RET_ADDR  output  ADDR_WIDTH  popped return address (registered)
OVF_EXC  output  1  sticky: CALL while stack full
UNF_EXC  output  1  sticky: RET while stack empty
BAD_REQ  output  1  one-cycle pulse: CALL and RET asserted together
DEPTH  output  DEPTH_WIDTH+1  current number of stacked entries

Behaviour:
- FSM states: IDLE, POP_WAIT, DELIVER, ERR. Reset (RST low, any time, including mid-pop) -> IDLE.
- Reset values: RET_ADDR=0, RET_VALID=0, OVF_EXC=0, UNF_EXC=0, BAD_REQ=0, DEPTH=0.
- Combinational outputs (STK_PUSH, STK_POP, STALL) are 0 during reset.
- IDLE, CALL&~RET&~STK_FULL:
  - STK_PUSH=1 and STK_DIN=CALL_PC in the same cycle.
  - DEPTH+1 at the edge; stay in IDLE; no stall.
- IDLE, CALL&~RET&STK_FULL:
  - No push; OVF_EXC<=1; -> ERR.
- IDLE, RET&~CALL&~STK_EMPTY:
  - STK_POP=1 and STALL=1 this cycle; DEPTH-1 at the edge; -> POP_WAIT.
- IDLE, RET&~CALL&STK_EMPTY:
  - No pop; UNF_EXC<=1; -> ERR.
- IDLE, CALL&RET:
  - No stack access; BAD_REQ pulses on the next cycle; stay in IDLE.
- POP_WAIT:
  - STALL=1; CALL and RET are ignored.
  - RET_ADDR<=STK_DOUT at the edge; -> DELIVER.
- DELIVER:
  - RET_VALID=1 for exactly this cycle; STALL=0; -> IDLE.
  - A new CALL or RET is not accepted in DELIVER; decode re-presents it in the following IDLE cycle.
- FLUSH:
  - In POP_WAIT or DELIVER, suppresses RET_VALID (forced 0) and returns the FSM to IDLE.
  - The stack entry is still consumed and DEPTH is not restored.
  - FLUSH in IDLE has no effect.
- Return latency: RET accepted at cycle N -> RET_VALID at N+2. STALL is high at cycles N and N+1.
- ERR:
  - STK_PUSH=STK_POP=STALL=0; CALL and RET are ignored.
  - CLR_EXC clears OVF_EXC and UNF_EXC and moves to IDLE at the next edge.
  - CLR_EXC in any other state clears the flags only.
- DEPTH:
  - Saturates at 0 and at 2**DEPTH_WIDTH.
  - DEPTH is informational only; STK_FULL and STK_EMPTY are authoritative for overflow and underflow decisions.
- Only one stack operation is issued per cycle; STK_PUSH and STK_POP are never high together.

Test Plan:
- Reset, then CALL with CALL_PC=0x00400008 for 1 cycle -> STK_PUSH=1 and STK_DIN=0x00400008 that cycle; DEPTH=1; STALL=0.
- After that push, RET at cycle N with the bench stack model returning 0x00400008 at N+1 -> STK_POP=1 at N; STALL=1 at N and N+1; RET_VALID=1 with RET_ADDR=0x00400008 at N+2; DEPTH=0.
- RET with STK_EMPTY=1 -> no STK_POP; UNF_EXC=1 and stays 1 while CALL/RET toggle; CLR_EXC=1 -> UNF_EXC=0 and FSM in IDLE next cycle.
- 64 CALLs with PCs 0x100, 0x108, ... then a 65th CALL with STK_FULL=1 -> no push; OVF_EXC=1; DEPTH=64.
- CALL and RET asserted together -> no PUSH/POP; BAD_REQ pulses for 1 cycle; DEPTH unchanged.
- RET accepted, FLUSH asserted in POP_WAIT -> RET_VALID never asserts; FSM back in IDLE; DEPTH decremented; a subsequent CALL pushes normally.
- RST driven low during POP_WAIT -> all outputs at reset values immediately; no RET_VALID after RST is released.

Source files
------------

// File: rtl/call_return_ctrl.sv
// Return-address stack client: turns decode CALL/RET into stack push/pop,
// hides the one-cycle pop latency behind a decode stall, and tracks sticky
// overflow/underflow exceptions plus a local depth count.
module call_return_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CALL,
  input  logic                   RET,
  input  logic [ADDR_WIDTH-1:0]  CALL_PC,
  input  logic                   FLUSH,
  input  logic                   CLR_EXC,
  input  logic                   STK_FULL,
  input  logic                   STK_EMPTY,
  input  logic [ADDR_WIDTH-1:0]  STK_DOUT,
  output logic                   STK_PUSH,
  output logic                   STK_POP,
  output logic [ADDR_WIDTH-1:0]  STK_DIN,
  output logic                   STALL,
  output logic                   RET_VALID,
  output logic [ADDR_WIDTH-1:0]  RET_ADDR,
  output logic                   OVF_EXC,
  output logic                   UNF_EXC,
  output logic                   BAD_REQ,
  output logic [DEPTH_WIDTH:0]   DEPTH
);

  typedef enum logic [1:0] {IDLE, POP_WAIT, DELIVER, ERR} state_t;

  localparam logic [DEPTH_WIDTH:0] DEPTH_MAX = {1'b1, {DEPTH_WIDTH{1'b0}}};

  state_t state, state_n;
  logic   push, pop, stall, rvalid, set_ovf, set_unf, bad;

  // Next-state and request decode; only IDLE accepts new CALL/RET.
  always_comb begin
    state_n = state;
    push    = 1'b0;
    pop     = 1'b0;
    stall   = 1'b0;
    rvalid  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    bad     = 1'b0;
    case (state)
      IDLE: begin
        if (CALL && RET) begin
          bad = 1'b1;
        end else if (CALL) begin
          if (STK_FULL) begin
            set_ovf = 1'b1;
            state_n = ERR;
          end else begin
            push = 1'b1;
          end
        end else if (RET) begin
          if (STK_EMPTY) begin
            set_unf = 1'b1;
            state_n = ERR;
          end else begin
            pop     = 1'b1;
            stall   = 1'b1;
            state_n = POP_WAIT;
          end
        end
      end
      POP_WAIT: begin
        stall   = 1'b1;
        state_n = FLUSH ? IDLE : DELIVER;
      end
      DELIVER: begin
        rvalid  = ~FLUSH;
        state_n = IDLE;
      end
      ERR: begin
        if (CLR_EXC) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Stack requests and stall are forced low while reset is held.
  assign STK_PUSH  = push  & RST;
  assign STK_POP   = pop   & RST;
  assign STALL     = stall & RST;
  assign RET_VALID = rvalid & RST;
  assign STK_DIN   = CALL_PC;

  // State, captured return address, sticky flags, depth counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      RET_ADDR <= '0;
      OVF_EXC  <= 1'b0;
      UNF_EXC  <= 1'b0;
      BAD_REQ  <= 1'b0;
      DEPTH    <= '0;
    end else begin
      state   <= state_n;
      BAD_REQ <= bad;
      // Pop data arrives the cycle after the pop request.
      if (state == POP_WAIT) RET_ADDR <= STK_DOUT;
      // A new fault in the same cycle as a clear leaves the flag set.
      if (set_ovf)      OVF_EXC <= 1'b1;
      else if (CLR_EXC) OVF_EXC <= 1'b0;
      if (set_unf)      UNF_EXC <= 1'b1;
      else if (CLR_EXC) UNF_EXC <= 1'b0;
      // Informational count, saturating at both ends.
      if (push && DEPTH != DEPTH_MAX) DEPTH <= DEPTH + 1'b1;
      else if (pop && DEPTH != '0)    DEPTH <= DEPTH - 1'b1;
    end
  end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl: a bench-side stack drives the flags
// and pop data; a timeline model predicts every output each cycle.
module tb_call_return_ctrl;
  localparam int AW  = 32;
  localparam int DW  = 6;
  localparam int CAP = 64;

  logic          CLK = 1'b0, RST = 1'b0;
  logic          CALL = 1'b0, RET = 1'b0, FLUSH = 1'b0, CLR_EXC = 1'b0;
  logic [AW-1:0] CALL_PC = '0;
  logic          STK_FULL, STK_EMPTY;
  logic [AW-1:0] STK_DOUT;
  logic          STK_PUSH, STK_POP, STALL, RET_VALID;
  logic          OVF_EXC, UNF_EXC, BAD_REQ;
  logic [AW-1:0] STK_DIN, RET_ADDR;
  logic [DW:0]   DEPTH;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  call_return_ctrl #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .CALL(CALL), .RET(RET), .CALL_PC(CALL_PC),
    .FLUSH(FLUSH), .CLR_EXC(CLR_EXC), .STK_FULL(STK_FULL),
    .STK_EMPTY(STK_EMPTY), .STK_DOUT(STK_DOUT), .STK_PUSH(STK_PUSH),
    .STK_POP(STK_POP), .STK_DIN(STK_DIN), .STALL(STALL),
    .RET_VALID(RET_VALID), .RET_ADDR(RET_ADDR), .OVF_EXC(OVF_EXC),
    .UNF_EXC(UNF_EXC), .BAD_REQ(BAD_REQ), .DEPTH(DEPTH)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bench stack: one-cycle pop latency, flags from its own pointer.
  logic [AW-1:0] mem [CAP];
  int            sp = 0;
  logic [AW-1:0] dout = '0;
  assign STK_FULL  = (sp == CAP);
  assign STK_EMPTY = (sp == 0);
  assign STK_DOUT  = dout;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sp   <= 0;
      dout <= '0;
    end else if (STK_PUSH) begin
      mem[sp] <= STK_DIN;
      sp      <= sp + 1;
    end else if (STK_POP) begin
      dout <= mem[sp-1];
      sp   <= sp - 1;
    end
  end

  // Timeline model: a RET taken at cycle N stalls N..N+1, delivers at N+2,
  // and nothing new is taken before N+3 unless a flush cut it short.
  logic [AW-1:0] m_q[$];
  int            m_depth = 0, cyc = 0, pop_n = -100, busy_until = -100;
  bit            m_err = 0, m_ovf = 0, m_unf = 0, m_bad = 0, cancel = 0;
  logic [AW-1:0] m_raddr = '0, pend = '0;
  bit            e_acc = 0, e_push = 0, e_pop = 0, e_full = 0, e_empty = 1;
  bit            e_stall, e_valid, chk_en = 0;

  // Compare process: predict and check every output mid-cycle.
  always @(negedge CLK) begin
    e_full  = (m_q.size() == CAP);
    e_empty = (m_q.size() == 0);
    e_acc   = RST && !m_err && (cyc > busy_until);
    e_push  = e_acc && CALL && !RET && !e_full;
    e_pop   = e_acc && RET && !CALL && !e_empty;
    e_stall = e_pop || (RST && cyc == pop_n + 1);
    e_valid = RST && (cyc == pop_n + 2) && !cancel && !FLUSH;
    if (chk_en) begin
      chk("STK_PUSH",  32'(STK_PUSH),  32'(e_push));
      chk("STK_POP",   32'(STK_POP),   32'(e_pop));
      chk("STK_DIN",   STK_DIN,        CALL_PC);
      chk("STALL",     32'(STALL),     32'(e_stall));
      chk("RET_VALID", 32'(RET_VALID), 32'(e_valid));
      chk("RET_ADDR",  RET_ADDR,       m_raddr);
      chk("OVF_EXC",   32'(OVF_EXC),   32'(m_ovf));
      chk("UNF_EXC",   32'(UNF_EXC),   32'(m_unf));
      chk("BAD_REQ",   32'(BAD_REQ),   32'(m_bad));
      chk("DEPTH",     32'(DEPTH),     32'(m_depth));
    end
  end

  // Model update at each clock edge; reset clears it immediately.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_q.delete();
      m_depth = 0; pop_n = -100; busy_until = -100;
      m_err = 0; m_ovf = 0; m_unf = 0; m_bad = 0; cancel = 0;
      m_raddr = '0;
    end else begin
      if (cyc == pop_n + 1) begin
        m_raddr = pend;
        if (FLUSH) begin
          cancel     = 1;
          busy_until = cyc;
        end
      end
      if (e_push) begin
        m_q.push_back(CALL_PC);
        if (m_depth < CAP) m_depth++;
      end
      if (e_pop) begin
        pend = m_q.pop_back();
        if (m_depth > 0) m_depth--;
        pop_n      = cyc;
        busy_until = cyc + 2;
        cancel     = 0;
      end
      m_bad = e_acc && CALL && RET;
      if (CLR_EXC) begin
        m_ovf = 0; m_unf = 0; m_err = 0;
      end
      if (e_acc && CALL && !RET && e_full)  begin m_ovf = 1; m_err = 1; end
      if (e_acc && RET && !CALL && e_empty) begin m_unf = 1; m_err = 1; end
    end
    cyc++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk_en = 1;
    @(negedge CLK);
    chk("rst RET_ADDR", RET_ADDR, 32'h0);
    chk("rst DEPTH", 32'(DEPTH), 32'd0);
    step(); RST = 1;

    // Single push
    CALL = 1; CALL_PC = 32'h00400008;
    @(negedge CLK);
    chk("push STK_PUSH", 32'(STK_PUSH), 32'd1);
    chk("push STK_DIN", STK_DIN, 32'h00400008);
    chk("push STALL", 32'(STALL), 32'd0);
    step(); CALL = 0;
    @(negedge CLK); chk("push DEPTH", 32'(DEPTH), 32'd1);

    // Return with 2-cycle latency
    step(); RET = 1;
    @(negedge CLK);
    chk("ret N STK_POP", 32'(STK_POP), 32'd1);
    chk("ret N STALL", 32'(STALL), 32'd1);
    step(); RET = 0;
    @(negedge CLK); chk("ret N+1 STALL", 32'(STALL), 32'd1);
    step();
    @(negedge CLK);
    chk("ret N+2 RET_VALID", 32'(RET_VALID), 32'd1);
    chk("ret N+2 RET_ADDR", RET_ADDR, 32'h00400008);
    chk("ret N+2 DEPTH", 32'(DEPTH), 32'd0);

    // Underflow, sticky through activity, then clear
    step(); RET = 1;
    @(negedge CLK); chk("unf STK_POP", 32'(STK_POP), 32'd0);
    step(); RET = 0;
    @(negedge CLK); chk("unf UNF_EXC", 32'(UNF_EXC), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); CALL = i[0]; RET = ~i[0];
      @(negedge CLK); chk("unf sticky", 32'(UNF_EXC), 32'd1);
    end
    step(); CALL = 0; RET = 0; CLR_EXC = 1;
    step(); CLR_EXC = 0; CALL = 1; CALL_PC = 32'h00400100;
    @(negedge CLK);
    chk("clr UNF_EXC", 32'(UNF_EXC), 32'd0);
    chk("clr idle push", 32'(STK_PUSH), 32'd1);
    step(); CALL = 0; RST = 0;
    step(); RST = 1;

    // Fill to 64, then overflow
    for (int i = 0; i < CAP; i++) begin
      CALL = 1; CALL_PC = 32'(32'h100 + 8 * i);
      step();
    end
    CALL_PC = 32'h300;
    @(negedge CLK); chk("ovf STK_PUSH", 32'(STK_PUSH), 32'd0);
    step(); CALL = 0;
    @(negedge CLK);
    chk("ovf OVF_EXC", 32'(OVF_EXC), 32'd1);
    chk("ovf DEPTH", 32'(DEPTH), 32'd64);
    step(); CLR_EXC = 1;
    step(); CLR_EXC = 0;
    @(negedge CLK); chk("ovf cleared", 32'(OVF_EXC), 32'd0);

    // CALL and RET together
    step(); CALL = 1; RET = 1;
    @(negedge CLK);
    chk("bad STK_PUSH", 32'(STK_PUSH), 32'd0);
    chk("bad STK_POP", 32'(STK_POP), 32'd0);
    step(); CALL = 0; RET = 0;
    @(negedge CLK);
    chk("bad BAD_REQ", 32'(BAD_REQ), 32'd1);
    chk("bad DEPTH", 32'(DEPTH), 32'd64);
    step();
    @(negedge CLK); chk("bad pulse end", 32'(BAD_REQ), 32'd0);

    // Flush during the pop wait
    step(); RET = 1;
    @(negedge CLK); chk("flush STK_POP", 32'(STK_POP), 32'd1);
    step(); RET = 0; FLUSH = 1;
    @(negedge CLK); chk("flush STALL", 32'(STALL), 32'd1);
    step(); FLUSH = 0;
    @(negedge CLK);
    chk("flush RET_VALID", 32'(RET_VALID), 32'd0);
    chk("flush DEPTH", 32'(DEPTH), 32'd63);
    step(); CALL = 1; CALL_PC = 32'h2000;
    @(negedge CLK); chk("flush then push", 32'(STK_PUSH), 32'd1);
    step(); CALL = 0;
    @(negedge CLK); chk("flush push DEPTH", 32'(DEPTH), 32'd64);

    // RET held high: re-presented each time the controller is idle again
    step(); RST = 0;
    step(); RST = 1;
    for (int i = 0; i < 3; i++) begin
      CALL = 1; CALL_PC = 32'(32'hA0 + 16 * i);
      step();
    end
    CALL = 0; RET = 1;
    step(); step();
    @(negedge CLK);
    chk("held RET_VALID", 32'(RET_VALID), 32'd1);
    chk("held RET_ADDR", RET_ADDR, 32'hC0);
    repeat (7) step();
    RET = 0;
    @(negedge CLK); chk("held DEPTH", 32'(DEPTH), 32'd0);

    // Reset in the middle of a pop
    step(); CALL = 1; CALL_PC = 32'h5550;
    step(); CALL = 0; RET = 1;
    step(); RET = 0; RST = 0;
    @(negedge CLK);
    chk("midrst STALL", 32'(STALL), 32'd0);
    chk("midrst RET_ADDR", RET_ADDR, 32'h0);
    chk("midrst DEPTH", 32'(DEPTH), 32'd0);
    step(); RST = 1;
    repeat (4) begin
      @(negedge CLK); chk("midrst no RET_VALID", 32'(RET_VALID), 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
